// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite command master: response codes, protection
// default and the master FSM state encoding.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY         = 2'b00;
  localparam logic [1:0] RESP_SLVERR       = 2'b10;
  localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StRsp
  } axil_state_e;

  // States in which the master is waiting on the slave and the timeout runs.
  function automatic logic is_wait_state(axil_state_e s);
    return (s == StWr) || (s == StWrResp) || (s == StRdAddr) || (s == StRdData);
  endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Saturating cycle counter with synchronous reload and a terminal flag.
// term_o is high while the count sits at Limit-1, i.e. during the Limit-th counted cycle.
module axil_timeout_cnt #(
  parameter int unsigned Limit = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic en_i,
  output logic term_o
);

  localparam int unsigned W = $clog2(Limit);
  localparam logic [W-1:0] Last = W'(Limit - 1);

  logic [W-1:0] cnt_d, cnt_q;

  // Reload wins over counting; hold at Last so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != Last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == Last);

endmodule

// File: rtl/m_axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: one command word in, one AXI-Lite
// transaction out, one response word back. All AXI and response outputs are registered.
module m_axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    axi_clock,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout_err,
  output logic                    busy,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [ADDR_WIDTH+1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  input  logic [1:0]              m_axil_bresp,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  output logic [ADDR_WIDTH+1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp
);

  axil_state_e state_d, state_q;
  logic cmd_ready_d, cmd_ready_q, busy_d, busy_q;
  logic awvalid_d, awvalid_q, wvalid_d, wvalid_q, bready_d, bready_q;
  logic arvalid_d, arvalid_q, rready_d, rready_q;
  logic [ADDR_WIDTH+1:0] awaddr_d, awaddr_q, araddr_d, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_d, wdata_q, rsp_rdata_d, rsp_rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_d, wstrb_q;
  logic rsp_valid_d, rsp_valid_q, rsp_write_d, rsp_write_q;
  logic [1:0] rsp_resp_d, rsp_resp_q;
  logic timeout_err_d, timeout_err_q;
  logic aw_hs, w_hs, wait_st, tmo_term;

  assign aw_hs   = awvalid_q & m_axil_awready;
  assign w_hs    = wvalid_q & m_axil_wready;
  assign wait_st = is_wait_state(state_q);

  // Timer restarts on every state change so each channel gets its own budget.
  axil_timeout_cnt #(
    .Limit (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i  (axi_clock),
    .rst_ni (rst_n),
    .load_i (state_d != state_q),
    .en_i   (wait_st),
    .term_o (tmo_term)
  );

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d       = state_q;
    cmd_ready_d   = cmd_ready_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    // Timeout only flags; the transaction keeps waiting to stay AXI compliant.
    timeout_err_d = timeout_err_q | (wait_st & tmo_term);

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            state_d   = StWr;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = {cmd_addr, 2'b00};
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = StRdAddr;
            arvalid_d = 1'b1;
            araddr_d  = {cmd_addr, 2'b00};
          end
        end
      end
      StWr: begin
        // AW and W retire independently; leave once neither is still pending.
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end
      end
      StWrResp: begin
        if (m_axil_bvalid && bready_q) begin
          bready_d    = 1'b0;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axil_bresp;
        end
      end
      StRdAddr: begin
        if (arvalid_q && m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        if (m_axil_rvalid && rready_q) begin
          rready_d    = 1'b0;
          state_d     = StRsp;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axil_rdata;
          rsp_resp_d  = m_axil_rresp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and registered outputs.
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cmd_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= RESP_OKAY;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign timeout_err    = timeout_err_q;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = AXIL_PROT_DEFAULT;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = AXIL_PROT_DEFAULT;
  assign m_axil_rready  = rready_q;

endmodule
